// File: rtl/tl_ul_mem_slave_if.sv
// TileLink-UL channel A / channel D bundle between a master and the memory slave.
interface tl_ul_mem_slave_if #(
    parameter int SOURCE_BITS = 4,
    parameter int ADDR_BITS   = 32
);
    logic                   a_valid;
    logic                   a_ready;
    logic [2:0]             a_opcode;
    logic [SOURCE_BITS-1:0] a_source;
    logic [ADDR_BITS-1:0]   a_address;
    logic [7:0]             a_mask;
    logic [63:0]            a_data;

    logic                   d_valid;
    logic                   d_ready;
    logic [3:0]             d_opcode;
    logic [SOURCE_BITS-1:0] d_source;
    logic [63:0]            d_data;
    logic                   d_denied;

    modport master (
        output a_valid, a_opcode, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_source, d_data, d_denied
    );

    modport slave (
        input  a_valid, a_opcode, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_source, d_data, d_denied
    );
endinterface

// File: rtl/tl_ul_mem_slave.sv
// TileLink-UL single-word memory slave with self-initialising 64-bit storage
// and observation strobes for a bus monitor.
//
// state  | meaning
// INIT   | fill memory with INIT_PATTERN | index, one word per cycle
// IDLE   | a_ready high, waiting for a channel A request
// ACCESS | one cycle: perform the latched write or registered read
// RESP   | d_valid high until the master takes the response
module tl_ul_mem_slave #(
    parameter int          MEM_DEPTH    = 1024,
    parameter int          SOURCE_BITS  = 4,
    parameter int          ADDR_BITS    = 32,
    parameter logic [63:0] INIT_PATTERN = 64'hAA00_0000_0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tl_ul_mem_slave_if.slave       bus,
    output logic                   mem_write_valid,
    output logic [ADDR_BITS-1:0]   mem_write_addr,
    output logic [63:0]            mem_write_data,
    output logic [7:0]             mem_write_mask,
    output logic                   mem_read_valid,
    output logic [ADDR_BITS-1:0]   mem_read_addr,
    output logic [63:0]            mem_read_data,
    output logic                   resp_valid,
    output logic [3:0]             resp_opcode,
    output logic [SOURCE_BITS-1:0] resp_source,
    output logic [63:0]            resp_data,
    output logic                   init_done
);
    localparam int IDX_BITS = $clog2(MEM_DEPTH);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(MEM_DEPTH - 1);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    state_t                 state;
    logic [IDX_BITS-1:0]    cnt;
    logic [2:0]             lat_opcode;
    logic [SOURCE_BITS-1:0] lat_source;
    logic [ADDR_BITS-1:0]   lat_address;
    logic [7:0]             lat_mask;
    logic [63:0]            lat_data;
    logic [63:0]            mem [MEM_DEPTH];

    function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr);
        return (addr >> 3) < ADDR_BITS'(MEM_DEPTH);
    endfunction

    function automatic logic is_put(input logic [2:0] op);
        return (op == OP_PUT_FULL) || (op == OP_PUT_PARTIAL);
    endfunction

    logic                lat_ok;
    logic [IDX_BITS-1:0] lat_idx;
    logic [7:0]          lat_wmask;

    assign lat_ok    = addr_in_range(lat_address);
    assign lat_idx   = lat_address[IDX_BITS+2:3];
    assign lat_wmask = (lat_opcode == OP_PUT_FULL) ? 8'hFF : lat_mask;

    // Monitor view of the accepted D beat; follows the registered D outputs.
    assign resp_valid  = bus.d_valid && bus.d_ready;
    assign resp_opcode = bus.d_opcode;
    assign resp_source = bus.d_source;
    assign resp_data   = bus.d_data;

    // Memory write port: init fill, then byte-masked puts in ACCESS.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                mem[cnt] <= INIT_PATTERN | 64'(cnt);
            end else if (state == ST_ACCESS && lat_ok && is_put(lat_opcode)) begin
                for (int b = 0; b < 8; b++) begin
                    if (lat_wmask[b]) mem[lat_idx][8*b +: 8] <= lat_data[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered bus and observation outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_INIT;
            cnt             <= '0;
            init_done       <= 1'b0;
            lat_opcode      <= '0;
            lat_source      <= '0;
            lat_address     <= '0;
            lat_mask        <= '0;
            lat_data        <= '0;
            bus.a_ready     <= 1'b0;
            bus.d_valid     <= 1'b0;
            bus.d_opcode    <= '0;
            bus.d_source    <= '0;
            bus.d_data      <= '0;
            bus.d_denied    <= 1'b0;
            mem_write_valid <= 1'b0;
            mem_write_addr  <= '0;
            mem_write_data  <= '0;
            mem_write_mask  <= '0;
            mem_read_valid  <= 1'b0;
            mem_read_addr   <= '0;
            mem_read_data   <= '0;
        end else begin
            mem_write_valid <= 1'b0;
            mem_read_valid  <= 1'b0;
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state       <= ST_IDLE;
                        init_done   <= 1'b1;
                        bus.a_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.a_valid && bus.a_ready) begin
                        lat_opcode  <= bus.a_opcode;
                        lat_source  <= bus.a_source;
                        lat_address <= bus.a_address;
                        lat_mask    <= bus.a_mask;
                        lat_data    <= bus.a_data;
                        bus.a_ready <= 1'b0;
                        state       <= ST_ACCESS;
                        // Strobe is raised for the ACCESS cycle, when the write lands.
                        if (addr_in_range(bus.a_address) && is_put(bus.a_opcode)) begin
                            mem_write_valid <= 1'b1;
                            mem_write_addr  <= bus.a_address;
                            mem_write_data  <= bus.a_data;
                            mem_write_mask  <= (bus.a_opcode == OP_PUT_FULL) ? 8'hFF : bus.a_mask;
                        end
                    end
                end
                ST_ACCESS: begin
                    state        <= ST_RESP;
                    bus.d_valid  <= 1'b1;
                    bus.d_source <= lat_source;
                    bus.d_data   <= '0;
                    if (lat_opcode == OP_GET) begin
                        bus.d_opcode <= 4'd1;
                        bus.d_denied <= !lat_ok;
                        if (lat_ok) begin
                            bus.d_data     <= mem[lat_idx];
                            mem_read_valid <= 1'b1;
                            mem_read_addr  <= lat_address;
                            mem_read_data  <= mem[lat_idx];
                        end
                    end else begin
                        bus.d_opcode <= 4'd0;
                        bus.d_denied <= !(lat_ok && is_put(lat_opcode));
                    end
                end
                ST_RESP: begin
                    if (bus.d_ready) begin
                        bus.d_valid <= 1'b0;
                        bus.a_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_tl_ul_mem_slave.sv
// Self-checking bench for tl_ul_mem_slave: scoreboard of expected D beats
// built from a reference memory model, one task per scenario.
module tb_tl_ul_mem_slave;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] PAT   = 64'hAA00_0000_0000_0000;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  source;
        logic [63:0] data;
        logic        denied;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_write_valid, mem_read_valid, resp_valid, init_done;
    logic [31:0] mem_write_addr, mem_read_addr;
    logic [63:0] mem_write_data, mem_read_data, resp_data;
    logic [7:0]  mem_write_mask;
    logic [3:0]  resp_opcode, resp_source;

    tl_ul_mem_slave_if #(.SOURCE_BITS(4), .ADDR_BITS(32)) bus ();

    tl_ul_mem_slave #(
        .MEM_DEPTH(DEPTH), .SOURCE_BITS(4), .ADDR_BITS(32), .INIT_PATTERN(PAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_write_mask(mem_write_mask),
        .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data), .resp_valid(resp_valid),
        .resp_opcode(resp_opcode), .resp_source(resp_source),
        .resp_data(resp_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    rsp_t        sb[$];
    logic [63:0] model_mem [DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = PAT | 64'(i);
    endtask

    // Reference behaviour of one request; pushes the expected D beat.
    task automatic model_push(input logic [2:0] op, input logic [3:0] src,
                              input logic [31:0] addr, input logic [7:0] mask,
                              input logic [63:0] data);
        rsp_t r;
        logic ok;
        int   idx;
        ok = (addr >> 3) < 32'(DEPTH);
        idx = int'(addr[12:3]);
        r.source = src;
        r.data = '0;
        r.denied = 1'b0;
        if (op == 3'd4) begin
            r.opcode = 4'd1;
            if (ok) r.data = model_mem[idx];
            else r.denied = 1'b1;
        end else if (op == 3'd0 || op == 3'd1) begin
            r.opcode = 4'd0;
            if (ok) begin
                for (int b = 0; b < 8; b++)
                    if (op == 3'd0 || mask[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
            end else begin
                r.denied = 1'b1;
            end
        end else begin
            r.opcode = 4'd0;
            r.denied = 1'b1;
        end
        sb.push_back(r);
    endtask

    // Present a request and return in the ACCESS cycle right after acceptance.
    task automatic do_req(input logic [2:0] op, input logic [3:0] src,
                          input logic [31:0] addr, input logic [7:0] mask,
                          input logic [63:0] data);
        int w;
        bus.a_opcode = op; bus.a_source = src; bus.a_address = addr;
        bus.a_mask = mask; bus.a_data = data; bus.a_valid = 1'b1;
        w = 0;
        while (!bus.a_ready && w < 50) begin tick(); w++; end
        n_cmp++;
        if (!bus.a_ready) begin
            n_bad++;
            $display("FAIL a_ready_timeout: a_ready=%b after %0d cycles, required 1", bus.a_ready, w);
        end
        tick();
        bus.a_valid = 1'b0;
        model_push(op, src, addr, mask, data);
    endtask

    task automatic await_resp(output rsp_t r, output int waited);
        waited = 0;
        while (!bus.d_valid && waited < 50) begin tick(); waited++; end
        r.opcode = bus.d_opcode;
        r.source = bus.d_source;
        r.data   = bus.d_data;
        r.denied = bus.d_denied;
    endtask

    task automatic wait_init(output int cycles, output bit saw_wr);
        cycles = 0;
        saw_wr = 0;
        while (!init_done && cycles < 3000) begin
            tick();
            cycles++;
            if (mem_write_valid) saw_wr = 1;
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit saw;
        rst_n = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({bus.a_ready, bus.d_valid, bus.d_opcode, bus.d_source, bus.d_data, bus.d_denied} !== '0) begin
            n_bad++;
            $display("FAIL reset_d: a_ready=%b d_valid=%b d_opcode=%h d_data=%h, required all 0",
                     bus.a_ready, bus.d_valid, bus.d_opcode, bus.d_data);
        end
        n_cmp++;
        if ({init_done, mem_write_valid, mem_read_valid, resp_valid, mem_write_mask} !== '0) begin
            n_bad++;
            $display("FAIL reset_obs: init_done=%b mwv=%b mrv=%b resp_valid=%b, required 0",
                     init_done, mem_write_valid, mem_read_valid, resp_valid);
        end
        rst_n = 1'b1;
        wait_init(cyc, saw);
        n_cmp++;
        if (cyc !== DEPTH) begin
            n_bad++;
            $display("FAIL init_cycles: init_done after %0d cycles, required %0d", cyc, DEPTH);
        end
        n_cmp++;
        if (saw !== 1'b0 || bus.a_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL init_strobes: mem_write_valid seen=%b a_ready=%b, required 0/1", saw, bus.a_ready);
        end
    endtask

    task automatic test_init_get();
        rsp_t r, e;
        int   w;
        do_req(3'd4, 4'd3, 32'h18, 8'h00, 64'h0);
        n_cmp++;
        if (bus.d_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL get_access_dvalid: d_valid=%b in ACCESS, required 0", bus.d_valid);
        end
        await_resp(r, w);
        e = sb.pop_front();
        n_cmp++;
        if (w !== 1 || r !== e || r.data !== 64'hAA00_0000_0000_0003) begin
            n_bad++;
            $display("FAIL get_18: wait=%0d op=%h src=%h data=%h den=%b, required wait=1 op=%h src=%h data=%h den=%b",
                     w, r.opcode, r.source, r.data, r.denied, e.opcode, e.source, e.data, e.denied);
        end
        n_cmp++;
        if (mem_read_valid !== 1'b1 || mem_read_addr !== 32'h18 || mem_read_data !== e.data || resp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL get_18_strobe: mrv=%b addr=%h data=%h resp_valid=%b, required 1/18/%h/1",
                     mem_read_valid, mem_read_addr, mem_read_data, resp_valid, e.data);
        end
        tick();
        n_cmp++;
        if (mem_read_valid !== 1'b0 || bus.d_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL get_18_after: mrv=%b d_valid=%b, required 0/0", mem_read_valid, bus.d_valid);
        end
    endtask

    task automatic test_put_full();
        rsp_t r, e;
        int   w;
        do_req(3'd0, 4'd1, 32'h40, 8'h00, 64'h1122334455667788);
        n_cmp++;
        if (mem_write_valid !== 1'b1 || mem_write_mask !== 8'hFF || mem_write_addr !== 32'h40 ||
            mem_write_data !== 64'h1122334455667788) begin
            n_bad++;
            $display("FAIL putfull_strobe: mwv=%b mask=%h addr=%h data=%h, required 1/ff/40/1122334455667788",
                     mem_write_valid, mem_write_mask, mem_write_addr, mem_write_data);
        end
        await_resp(r, w);
        e = sb.pop_front();
        n_cmp++;
        if (w !== 1 || r !== e) begin
            n_bad++;
            $display("FAIL putfull_ack: wait=%0d op=%h src=%h data=%h den=%b, required op=%h src=%h data=%h den=%b",
                     w, r.opcode, r.source, r.data, r.denied, e.opcode, e.source, e.data, e.denied);
        end
        tick();
        do_req(3'd4, 4'd2, 32'h40, 8'h00, 64'h0);
        await_resp(r, w);
        e = sb.pop_front();
        n_cmp++;
        if (w !== 1 || r !== e || r.data !== 64'h1122334455667788) begin
            n_bad++;
            $display("FAIL putfull_readback: data=%h op=%h den=%b, required data=%h op=%h den=%b",
                     r.data, r.opcode, r.denied, e.data, e.opcode, e.denied);
        end
        tick();
    endtask

    task automatic test_put_partial();
        rsp_t r, e;
        int   w;
        do_req(3'd1, 4'd6, 32'h40, 8'h0F, 64'hFFFFFFFFAABBCCDD);
        n_cmp++;
        if (mem_write_valid !== 1'b1 || mem_write_mask !== 8'h0F) begin
            n_bad++;
            $display("FAIL putpartial_strobe: mwv=%b mask=%h, required 1/0f", mem_write_valid, mem_write_mask);
        end
        await_resp(r, w);
        e = sb.pop_front();
        n_cmp++;
        if (w !== 1 || r !== e) begin
            n_bad++;
            $display("FAIL putpartial_ack: op=%h src=%h data=%h den=%b, required op=%h src=%h data=%h den=%b",
                     r.opcode, r.source, r.data, r.denied, e.opcode, e.source, e.data, e.denied);
        end
        tick();
        do_req(3'd4, 4'd6, 32'h40, 8'h00, 64'h0);
        await_resp(r, w);
        e = sb.pop_front();
        n_cmp++;
        if (w !== 1 || r !== e || r.data !== 64'h11223344AABBCCDD) begin
            n_bad++;
            $display("FAIL putpartial_merge: data=%h, required %h (model) and 11223344aabbccdd", r.data, e.data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        rsp_t r, snap, e;
        int   w;
        bit   moved, rdy_seen;
        bus.d_ready = 1'b0;
        do_req(3'd4, 4'd5, 32'h18, 8'h00, 64'h0);
        await_resp(snap, w);
        e = sb.pop_front();
        n_cmp++;
        if (w !== 1 || snap !== e) begin
            n_bad++;
            $display("FAIL bp_first: data=%h src=%h, required data=%h src=%h", snap.data, snap.source, e.data, e.source);
        end
        bus.a_opcode = 3'd4; bus.a_source = 4'd7; bus.a_address = 32'h40;
        bus.a_mask = 8'h00; bus.a_data = 64'h0; bus.a_valid = 1'b1;
        moved = 0;
        rdy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            r.opcode = bus.d_opcode; r.source = bus.d_source; r.data = bus.d_data; r.denied = bus.d_denied;
            if (r !== snap || bus.d_valid !== 1'b1 || resp_valid !== 1'b0) moved = 1;
            if (bus.a_ready !== 1'b0) rdy_seen = 1;
        end
        n_cmp++;
        if (moved !== 1'b0 || rdy_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_stall: d changed=%b a_ready seen=%b, required 0/0", moved, rdy_seen);
        end
        bus.d_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.d_valid !== 1'b0 || bus.a_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_handshake: d_valid=%b a_ready=%b, required 0/1", bus.d_valid, bus.a_ready);
        end
        tick();
        bus.a_valid = 1'b0;
        model_push(3'd4, 4'd7, 32'h40, 8'h00, 64'h0);
        n_cmp++;
        if (bus.a_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_accept: a_ready=%b after second accept, required 0", bus.a_ready);
        end
        await_resp(r, w);
        e = sb.pop_front();
        n_cmp++;
        if (w !== 1 || r !== e) begin
            n_bad++;
            $display("FAIL bp_second: wait=%0d data=%h src=%h, required wait=1 data=%h src=%h",
                     w, r.data, r.source, e.data, e.source);
        end
        tick();
    endtask

    task automatic test_errors();
        rsp_t r, e;
        int   w;
        do_req(3'd4, 4'd9, 32'h2000, 8'h00, 64'h0);
        await_resp(r, w);
        e = sb.pop_front();
        n_cmp++;
        if (w !== 1 || r !== e || r.denied !== 1'b1 || mem_read_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL err_get_oor: op=%h data=%h den=%b mrv=%b, required op=%h data=%h den=1 mrv=0",
                     r.opcode, r.data, r.denied, mem_read_valid, e.opcode, e.data);
        end
        tick();
        do_req(3'd2, 4'd10, 32'h40, 8'hFF, 64'hDEADBEEF);
        n_cmp++;
        if (mem_write_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL err_opc_write: mem_write_valid=%b, required 0", mem_write_valid);
        end
        await_resp(r, w);
        e = sb.pop_front();
        n_cmp++;
        if (w !== 1 || r !== e || mem_read_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL err_opcode2: op=%h data=%h den=%b mrv=%b, required op=%h data=%h den=%b mrv=0",
                     r.opcode, r.data, r.denied, mem_read_valid, e.opcode, e.data, e.denied);
        end
        tick();
    endtask

    task automatic test_reset_mid_resp();
        rsp_t r, e;
        int   w, cyc;
        bit   saw;
        do_req(3'd0, 4'd4, 32'h40, 8'hFF, 64'h5);
        await_resp(r, w);
        sb.delete();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (bus.d_valid !== 1'b0 || bus.a_ready !== 1'b0 || init_done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_resp: d_valid=%b a_ready=%b init_done=%b, required 0/0/0",
                     bus.d_valid, bus.a_ready, init_done);
        end
        rst_n = 1'b1;
        model_init();
        wait_init(cyc, saw);
        n_cmp++;
        if (cyc !== DEPTH) begin
            n_bad++;
            $display("FAIL rst_reinit: init_done after %0d cycles, required %0d", cyc, DEPTH);
        end
        do_req(3'd4, 4'd8, 32'h40, 8'h00, 64'h0);
        await_resp(r, w);
        e = sb.pop_front();
        n_cmp++;
        if (w !== 1 || r !== e || r.data !== 64'hAA00_0000_0000_0008) begin
            n_bad++;
            $display("FAIL rst_readback: data=%h, required %h and aa00000000000008", r.data, e.data);
        end
        tick();
    endtask

    initial begin
        bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_source = '0; bus.a_address = '0;
        bus.a_mask = '0; bus.a_data = '0; bus.d_ready = 1'b1;
        model_init();
        test_reset();
        test_init_get();
        test_put_full();
        test_put_partial();
        test_backpressure();
        test_errors();
        test_reset_mid_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
